// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  // Arbiter state: IDLE means no grant was issued last cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Requester IDs, also the encoding of the "last winner" flag.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Ownership state that corresponds to a requester ID.
  function automatic state_t own_state(input logic id);
    return (id == REQ1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester handshakes plus the memory-side bus of the arbiter.
interface dm_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0, we0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Requester/memory side (testbench, datapath, memory).
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
    input  mem_w, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
    output mem_w, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_rr_pick.sv
// Combinational winner select: round-robin with a bounded burst length.
module dm_rr_pick
  import dm_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic          req0,
  input  logic          req1,
  input  state_t        state,
  input  logic          last,
  input  logic [CW-1:0] cnt,
  output logic          gnt0,
  output logic          gnt1
);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  // Lone requester wins; on contention the owner keeps it until the burst is spent.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      case (state)
        OWN0: if (cnt < MAX_C) gnt0 = 1'b1; else gnt1 = 1'b1;
        OWN1: if (cnt < MAX_C) gnt1 = 1'b1; else gnt0 = 1'b1;
        default: if (last == REQ1) gnt0 = 1'b1; else gnt1 = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter sharing one single-port data memory between requesters.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input logic         clk,
  input logic         rst_n,
  dm_arbiter_if.slave bus
);
  localparam int            CW    = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_reg, last_next;
  logic          gnt0_raw, gnt1_raw;
  logic [1:0]    gnt_vec, we_vec;
  logic          mem_w_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  dm_rr_pick #(.MAX_BURST(MAX_BURST), .CW(CW)) u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .state(state_reg),
    .last (last_reg),
    .cnt  (cnt_reg),
    .gnt0 (gnt0_raw),
    .gnt1 (gnt1_raw)
  );

  assign gnt_vec = {gnt1_raw, gnt0_raw};
  assign we_vec  = {bus.we1, bus.we0};

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= REQ1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  // Next ownership and saturating burst count from this cycle's winner.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    if (!(gnt0_raw || gnt1_raw)) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state_reg == own_state(gnt1_raw)) begin
      cnt_next = (cnt_reg == MAX_C) ? cnt_reg : cnt_reg + CW'(1);
    end else begin
      state_next = own_state(gnt1_raw);
      cnt_next   = CW'(1);
      last_next  = gnt1_raw;
    end
  end

  // Memory-side mux; requester 0 drives address/data when nobody is granted.
  always_comb begin
    mem_w_sel = 1'b0;
    addr_sel  = bus.addr0;
    wdata_sel = bus.wdata0;
    if (gnt1_raw) begin
      mem_w_sel = bus.we1;
      addr_sel  = bus.addr1;
      wdata_sel = bus.wdata1;
    end else if (gnt0_raw) begin
      mem_w_sel = bus.we0;
    end
  end

  // Grants and write enable are gated by reset so nothing reaches memory mid-reset.
  assign bus.gnt0      = gnt0_raw & rst_n;
  assign bus.gnt1      = gnt1_raw & rst_n;
  assign bus.mem_w     = mem_w_sel & rst_n;
  assign bus.mem_addr  = rst_n ? addr_sel : '0;
  assign bus.mem_wdata = rst_n ? wdata_sel : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      logic [DW-1:0] rdata_reg;
      logic          rvalid_reg;
      // Capture read data at the granting edge; valid strobes for one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= gnt_vec[gi] & ~we_vec[gi];
          if (gnt_vec[gi] && !we_vec[gi]) rdata_reg <= bus.mem_rdata;
        end
      end
    end
  endgenerate

  assign bus.rdata0  = g_ret[0].rdata_reg;
  assign bus.rvalid0 = g_ret[0].rvalid_reg;
  assign bus.rdata1  = g_ret[1].rdata_reg;
  assign bus.rvalid1 = g_ret[1].rvalid_reg;
endmodule

// File: tb/tb_dm_arbiter.sv
// Table-driven bench for dm_arbiter with a read-return scoreboard.
module tb_dm_arbiter;
  import dm_pkg::*;

  typedef struct {
    logic       rst_n;
    logic       req0, we0;
    logic [7:0] addr0, wdata0;
    logic       req1, we1;
    logic [7:0] addr1, wdata1;
    logic       gnt0, gnt1;
  } vec_t;

  typedef struct {
    logic       rv0, rv1;
    logic [7:0] d0, d1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  vec_t       tbl [$];
  exp_t       sb [$];
  int         n_vec = 0;
  int         n_miss = 0;

  dm_arbiter_if #(.AW(8), .DW(8)) bus ();

  dm_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the rising edge.
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_w) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r,
                              input logic q0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                              input logic q1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.rst_n = r;
    v.req0 = q0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.gnt0 = g0; v.gnt1 = g1;
    tbl.push_back(v);
  endfunction

  task automatic check_return();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 8'(sb.size()), 8'd1);
      return;
    end
    e = sb.pop_front();
    chk("rvalid0", 8'(bus.rvalid0), 8'(e.rv0));
    chk("rvalid1", 8'(bus.rvalid1), 8'(e.rv1));
    if (e.rv0) chk("rdata0", bus.rdata0, e.d0);
    if (e.rv1) chk("rdata1", bus.rdata1, e.d1);
  endtask

  // One cycle: drive at the falling edge, check mid-cycle, queue the read return.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    logic [7:0] ea, ed;
    logic       ew;
    @(negedge clk);
    rst_n = v.rst_n;
    bus.req0 = v.req0; bus.we0 = v.we0; bus.addr0 = v.addr0; bus.wdata0 = v.wdata0;
    bus.req1 = v.req1; bus.we1 = v.we1; bus.addr1 = v.addr1; bus.wdata1 = v.wdata1;
    #1;
    check_return();
    ew = (v.gnt0 & v.we0) | (v.gnt1 & v.we1);
    ea = !v.rst_n ? 8'h00 : (v.gnt1 ? v.addr1 : v.addr0);
    ed = !v.rst_n ? 8'h00 : (v.gnt1 ? v.wdata1 : v.wdata0);
    chk("gnt0", 8'(bus.gnt0), 8'(v.gnt0));
    chk("gnt1", 8'(bus.gnt1), 8'(v.gnt1));
    chk("mem_w", 8'(bus.mem_w), 8'(ew));
    chk("mem_addr", bus.mem_addr, ea);
    if (ew || !v.rst_n) chk("mem_wdata", bus.mem_wdata, ed);
    if (!v.rst_n) begin
      chk("rdata0_rst", bus.rdata0, 8'h00);
      chk("rdata1_rst", bus.rdata1, 8'h00);
      chk("state_rst", 8'(dut.state_reg), 8'(IDLE));
    end
    e.rv0 = v.gnt0 & ~v.we0;
    e.rv1 = v.gnt1 & ~v.we1;
    e.d0  = ref_mem[v.addr0];
    e.d1  = ref_mem[v.addr1];
    sb.push_back(e);
    if (v.gnt0 && v.we0) ref_mem[v.addr0] = v.wdata0;
    if (v.gnt1 && v.we1) ref_mem[v.addr1] = v.wdata1;
    $display("vec %0d: rst_n=%b req=%b%b gnt=%b%b mem_w=%b addr=%h rv=%b%b",
             idx, v.rst_n, v.req1, v.req0, bus.gnt1, bus.gnt0, bus.mem_w,
             bus.mem_addr, bus.rvalid1, bus.rvalid0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e0;
    vec_t v;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // Reset held with both requesting, then first tie goes to requester 0.
    add(0, 1,0,8'h00,8'h00, 1,0,8'h01,8'h00, 0,0);
    add(0, 1,0,8'h00,8'h00, 1,0,8'h01,8'h00, 0,0);
    add(1, 1,0,8'h00,8'h00, 1,0,8'h01,8'h00, 1,0);
    // Single write then read-back.
    add(1, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0);
    add(1, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0);
    // Requester 1 served, idle, then contention: 0 wins the tie, bursts of 4.
    add(1, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,1);
    add(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0);
    for (int i = 0; i < 12; i++)
      add(1, 1,0,8'h10,8'h00, 1,0,8'h30,8'h00, (i < 4 || i >= 8), (i >= 4 && i < 8));
    add(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0);
    // Solo stream on requester 1, then requester 0 gets in at once.
    for (int i = 0; i < 10; i++)
      add(1, 0,0,8'h00,8'h00, 1,1,8'h40,8'h3C, 0,1);
    add(1, 1,0,8'h40,8'h00, 1,1,8'h40,8'h3C, 1,0);
    add(1, 1,0,8'h40,8'h00, 1,1,8'h40,8'h3C, 1,0);
    add(1, 0,0,8'h00,8'h00, 1,1,8'h40,8'h3C, 0,1);
    // Read by requester 0 just before reset is hit.
    add(1, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0);

    e0.rv0 = 1'b0; e0.rv1 = 1'b0; e0.d0 = 8'h00; e0.d1 = 8'h00;
    sb.push_back(e0);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Reset mid-burst: read return visible, then async reset clears it at once.
    @(posedge clk);
    #2;
    check_return();
    rst_n = 1'b0;
    bus.we0 = 1'b1; bus.wdata0 = 8'hFF;
    #1;
    chk("rvalid0_async_rst", 8'(bus.rvalid0), 8'h00);
    chk("gnt0_async_rst", 8'(bus.gnt0), 8'h00);
    chk("mem_w_async_rst", 8'(bus.mem_w), 8'h00);
    $display("mid-burst reset: rvalid0=%b gnt0=%b mem_w=%b", bus.rvalid0, bus.gnt0, bus.mem_w);
    sb.push_back(e0);
    v = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    step(v, 100);
    // After release: IDLE with last=1, so requester 0 wins; memory still holds A5.
    v = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0};
    step(v, 101);
    v = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    step(v, 102);
    step(v, 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
